gumnut_ctrl: RTL and testbench

Multi-cycle control unit that sequences the Gumnut datapath (`punit`). It does the following:
- fetches 18-bit instructions over the instruction bus;
- decodes the IR fields that `punit` returns;
- drives every datapath control input;
- runs the data and I/O-port bus cycles;
- owns the PC, the return stack and interrupt entry/exit.

It sits between `punit` and the instruction/data/port memories, at the top of the processor.

---
 rtl/gumnut_ctrl_pkg.sv | 86 ++++++++
 rtl/gumnut_ctrl_ret_stack.sv | 48 ++++
 rtl/gumnut_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_gumnut_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_ctrl_pkg.sv
// gumnut_ctrl_pkg
// Shared types and constants for the Gumnut control unit:
//   - state_t     : control FSM states
//   - op_class_t  : instruction class decoded from IR bits [17:11]
//   - ALU_*       : ALU operation codes driven on ALUOp_c_o
//   - MUX_*       : register-file write-data sources driven on RegMux_c_o
//   - MEM_*, BR_*, MISC_* : sub-op codes carried in func
//   - decode_op() : op -> instruction class
package gumnut_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_INT,
    ST_WAIT,
    ST_STBY
  } state_t;

  typedef enum logic [2:0] {
    CL_ALUI,
    CL_MEM,
    CL_ALUR,
    CL_SHIFT,
    CL_JUMP,
    CL_BRANCH,
    CL_MISC,
    CL_NOP
  } op_class_t;

  // ALU operations: arithmetic/logic ops 0..7, shifts/rotates 8..11
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDC = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBC = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_MASK = 4'd7;
  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_SHR  = 4'd9;
  localparam logic [3:0] ALU_ROL  = 4'd10;
  localparam logic [3:0] ALU_ROR  = 4'd11;

  // Register-file write-data source
  localparam logic [1:0] MUX_ALU  = 2'd0;
  localparam logic [1:0] MUX_DMEM = 2'd1;
  localparam logic [1:0] MUX_PORT = 2'd2;

  // Memory sub-ops (func[1:0]): bit 1 selects the port bus, bit 0 is a write
  localparam logic [1:0] MEM_LDM = 2'd0;
  localparam logic [1:0] MEM_STM = 2'd1;
  localparam logic [1:0] MEM_INP = 2'd2;
  localparam logic [1:0] MEM_OUT = 2'd3;

  // Branch conditions (func[1:0])
  localparam logic [1:0] BR_Z  = 2'd0;
  localparam logic [1:0] BR_NZ = 2'd1;
  localparam logic [1:0] BR_C  = 2'd2;
  localparam logic [1:0] BR_NC = 2'd3;

  // Miscellaneous sub-ops (func); 6 and 7 behave as nop
  localparam logic [2:0] MISC_RET  = 3'd0;
  localparam logic [2:0] MISC_RETI = 3'd1;
  localparam logic [2:0] MISC_ENAI = 3'd2;
  localparam logic [2:0] MISC_DISI = 3'd3;
  localparam logic [2:0] MISC_WAIT = 3'd4;
  localparam logic [2:0] MISC_STBY = 3'd5;

  // The class is given by the position of the first zero in op, scanning
  // from the MSB; all ones is a nop.
  function automatic op_class_t decode_op(input logic [6:0] op);
    op_class_t cls;
    if (!op[6])      cls = CL_ALUI;
    else if (!op[5]) cls = CL_MEM;
    else if (!op[4]) cls = CL_ALUR;
    else if (!op[3]) cls = CL_SHIFT;
    else if (!op[2]) cls = CL_JUMP;
    else if (!op[1]) cls = CL_BRANCH;
    else if (!op[0]) cls = CL_MISC;
    else             cls = CL_NOP;
    return cls;
  endfunction

endpackage

// File: rtl/gumnut_ctrl_ret_stack.sv
// gumnut_ctrl_ret_stack
// Return-address LIFO, DEPTH x 12 bits, with a wrapping stack pointer.
// Push writes at sp and increments it; pop decrements it and the value at
// sp-1 is presented combinationally so the caller can load it in the same
// cycle. Overflow silently overwrites the oldest entry, underflow returns
// whatever stale entry the pointer lands on.
// Ports:
//   clk        clock
//   srst       synchronous active-high reset (pointer only)
//   push/pop   one-cycle requests, never both at once
//   push_data  value to push
//   pop_data   entry at sp-1
module gumnut_ctrl_ret_stack #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        push,
  input  logic        pop,
  input  logic [11:0] push_data,
  output logic [11:0] pop_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] sp_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sp_reg <= '0;
    end else if (push) begin
      sp_reg <= sp_reg + AW'(1);
    end else if (pop) begin
      sp_reg <= sp_reg - AW'(1);
    end
  end

  // Contents are never cleared; a pop after reset returns stale data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[sp_reg] <= push_data;
    end
  end

  assign pop_data = mem[sp_reg - AW'(1)];

endmodule

// File: rtl/gumnut_ctrl.sv
// gumnut_ctrl
// Multi-cycle control unit for the Gumnut datapath (punit). Fetches an
// instruction, lets punit latch it, decodes the class and sequences the
// datapath, the data/port bus cycles, the PC, the return stack and
// interrupt entry/exit.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   inst_cyc_o/stb_o/adr_o/ack_i  instruction fetch bus (adr = PC)
//   data_cyc_o/stb_o/we_o/ack_i   data-memory bus cycle
//   port_cyc_o/stb_o/we_o/ack_i   I/O-port bus cycle
//   bus_adr_o                     data/port address, registered from res_i
//   op_i, func_i, addr_i, disp_i  IR fields returned by punit
//   res_i, ccC_i, ccZ_i           ALU result and registered flags
//   int_req_i, int_ack_o          level interrupt request, entry pulse
//   ClkEn_o ... ALUOp_c_o         datapath controls
//   pc_o                          current PC (debug)
// Every control is a register updated on the transition into the state
// that uses it. The one exception is the register write of a load, which
// is qualified by the bus ack so that wait cycles never write the file.
module gumnut_ctrl
  import gumnut_ctrl_pkg::*;
#(
  parameter int          RS_DEPTH   = 8,
  parameter logic [11:0] INT_VECTOR = 12'h001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        inst_cyc_o,
  output logic        inst_stb_o,
  output logic [11:0] inst_adr_o,
  input  logic        inst_ack_i,
  output logic        data_cyc_o,
  output logic        data_stb_o,
  output logic        data_we_o,
  output logic        port_cyc_o,
  output logic        port_stb_o,
  output logic        port_we_o,
  input  logic        data_ack_i,
  input  logic        port_ack_i,
  output logic [7:0]  bus_adr_o,
  input  logic [6:0]  op_i,
  input  logic [2:0]  func_i,
  input  logic [11:0] addr_i,
  input  logic [7:0]  disp_i,
  input  logic [7:0]  res_i,
  input  logic        ccC_i,
  input  logic        ccZ_i,
  input  logic        int_req_i,
  output logic        int_ack_o,
  output logic        ClkEn_o,
  output logic        RegWrt_c_o,
  output logic        op2_c_o,
  output logic        stm_mux_o,
  output logic        ALUFR_c_o,
  output logic        ALUEn_c_o,
  output logic        reti_c_o,
  output logic [1:0]  RegMux_c_o,
  output logic [3:0]  ALUOp_c_o,
  output logic [11:0] pc_o
);

  state_t      state_reg;
  logic [11:0] pc_reg;
  logic        int_en_reg;
  logic        int_en_next;

  logic        inst_stb_reg;
  logic        data_stb_reg;
  logic        port_stb_reg;
  logic        we_reg;
  logic        stm_mux_reg;
  logic        mem_load_reg;
  logic [7:0]  bus_adr_reg;
  logic        int_ack_reg;
  logic        clk_en_reg;
  logic        reg_wrt_reg;
  logic [1:0]  reg_mux_reg;
  logic        op2_reg;
  logic        alufr_reg;
  logic        aluen_reg;
  logic        reti_reg;
  logic [3:0]  aluop_reg;

  op_class_t   cls;
  logic        push;
  logic        pop;
  logic [11:0] push_data;
  logic [11:0] pop_data;
  logic        int_take;
  logic        branch_taken;
  logic [11:0] pc_inc;
  logic [11:0] branch_target;
  logic        bus_ack;

  // IR is stable from the fetch ack until the next fetch ack, so the
  // class can be decoded straight from punit's fields.
  assign cls           = decode_op(op_i);
  assign pc_inc        = pc_reg + 12'd1;
  assign branch_target = pc_inc + {{4{disp_i[7]}}, disp_i};
  assign bus_ack       = (data_stb_reg & data_ack_i) | (port_stb_reg & port_ack_i);

  always_comb begin
    branch_taken = 1'b0;
    case (func_i[1:0])
      BR_Z:    branch_taken = ccZ_i;
      BR_NZ:   branch_taken = ~ccZ_i;
      BR_C:    branch_taken = ccC_i;
      BR_NC:   branch_taken = ~ccC_i;
      default: branch_taken = 1'b0;
    endcase
  end

  // Interrupt-enable update and return-stack requests for this cycle.
  always_comb begin
    int_en_next = int_en_reg;
    push        = 1'b0;
    pop         = 1'b0;
    push_data   = pc_inc;
    case (state_reg)
      ST_INT: begin
        int_en_next = 1'b0;
        push        = 1'b1;
        push_data   = pc_reg;
      end
      ST_EXECUTE: begin
        if (cls == CL_JUMP) begin
          push = func_i[0];
        end else if (cls == CL_MISC) begin
          case (func_i)
            MISC_RET:  pop = 1'b1;
            MISC_RETI: begin
              pop         = 1'b1;
              int_en_next = 1'b1;
            end
            MISC_ENAI: int_en_next = 1'b1;
            MISC_DISI: int_en_next = 1'b0;
            default:   ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Interrupts are only taken on the way into FETCH (or out of WAIT/STBY).
  // Using the updated enable means disi takes effect before the next fetch.
  assign int_take = int_en_next & int_req_i;

  gumnut_ctrl_ret_stack #(
    .DEPTH(RS_DEPTH)
  ) ret_stack (
    .clk       (clk_i),
    .srst      (rst_i),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .pop_data  (pop_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_FETCH;
      pc_reg       <= '0;
      int_en_reg   <= 1'b0;
      inst_stb_reg <= 1'b0;
      data_stb_reg <= 1'b0;
      port_stb_reg <= 1'b0;
      we_reg       <= 1'b0;
      stm_mux_reg  <= 1'b0;
      mem_load_reg <= 1'b0;
      bus_adr_reg  <= '0;
      int_ack_reg  <= 1'b0;
      clk_en_reg   <= 1'b1;
      reg_wrt_reg  <= 1'b0;
      reg_mux_reg  <= MUX_ALU;
      op2_reg      <= 1'b0;
      alufr_reg    <= 1'b0;
      aluen_reg    <= 1'b0;
      reti_reg     <= 1'b0;
      aluop_reg    <= ALU_ADD;
    end else begin
      int_en_reg <= int_en_next;

      // Controls that live for exactly one state default off.
      int_ack_reg <= 1'b0;
      clk_en_reg  <= 1'b1;
      reg_wrt_reg <= 1'b0;
      op2_reg     <= 1'b0;
      alufr_reg   <= 1'b0;
      aluen_reg   <= 1'b0;
      reti_reg    <= 1'b0;
      aluop_reg   <= ALU_ADD;

      case (state_reg)
        ST_FETCH: begin
          if (!inst_stb_reg) begin
            // Only reached straight after reset: raise the fetch request.
            if (int_take) begin
              state_reg   <= ST_INT;
              int_ack_reg <= 1'b1;
            end else begin
              inst_stb_reg <= 1'b1;
            end
          end else if (inst_ack_i) begin
            inst_stb_reg <= 1'b0;
            state_reg    <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          state_reg <= ST_EXECUTE;
          case (cls)
            CL_ALUI, CL_ALUR: begin
              aluen_reg   <= 1'b1;
              reg_wrt_reg <= 1'b1;
              alufr_reg   <= 1'b1;
              op2_reg     <= (cls == CL_ALUI);
              aluop_reg   <= {1'b0, func_i};
            end
            CL_SHIFT: begin
              aluen_reg   <= 1'b1;
              reg_wrt_reg <= 1'b1;
              alufr_reg   <= 1'b1;
              aluop_reg   <= ALU_SHL | {2'b00, func_i[1:0]};
            end
            CL_MEM: begin
              // ALU forms rs + immediate as the bus address.
              op2_reg   <= 1'b1;
              aluop_reg <= ALU_ADD;
            end
            CL_MISC: begin
              reti_reg <= (func_i == MISC_RETI);
            end
            default: ;
          endcase
        end

        ST_EXECUTE: begin
          if (cls == CL_MEM) begin
            state_reg    <= ST_MEM;
            bus_adr_reg  <= res_i;
            data_stb_reg <= ~func_i[1];
            port_stb_reg <= func_i[1];
            we_reg       <= func_i[0];
            stm_mux_reg  <= func_i[0];
            mem_load_reg <= ~func_i[0];
            if (func_i[0]) begin
              reg_mux_reg <= MUX_ALU;
            end else if (func_i[1]) begin
              reg_mux_reg <= MUX_PORT;
            end else begin
              reg_mux_reg <= MUX_DMEM;
            end
          end else if (cls == CL_MISC && func_i == MISC_WAIT) begin
            state_reg <= ST_WAIT;
          end else if (cls == CL_MISC && func_i == MISC_STBY) begin
            state_reg  <= ST_STBY;
            clk_en_reg <= 1'b0;
          end else begin
            case (cls)
              CL_BRANCH: pc_reg <= branch_taken ? branch_target : pc_inc;
              CL_JUMP:   pc_reg <= addr_i;
              CL_MISC:   pc_reg <= pop ? pop_data : pc_inc;
              default:   pc_reg <= pc_inc;
            endcase
            if (int_take) begin
              state_reg   <= ST_INT;
              int_ack_reg <= 1'b1;
            end else begin
              state_reg    <= ST_FETCH;
              inst_stb_reg <= 1'b1;
            end
          end
        end

        ST_MEM: begin
          // Strobes and the load write enable hold until the ack.
          if (bus_ack) begin
            data_stb_reg <= 1'b0;
            port_stb_reg <= 1'b0;
            we_reg       <= 1'b0;
            stm_mux_reg  <= 1'b0;
            mem_load_reg <= 1'b0;
            reg_mux_reg  <= MUX_ALU;
            pc_reg       <= pc_inc;
            if (int_take) begin
              state_reg   <= ST_INT;
              int_ack_reg <= 1'b1;
            end else begin
              state_reg    <= ST_FETCH;
              inst_stb_reg <= 1'b1;
            end
          end
        end

        ST_INT: begin
          // The return stack pushes the current PC this cycle.
          pc_reg       <= INT_VECTOR;
          state_reg    <= ST_FETCH;
          inst_stb_reg <= 1'b1;
        end

        ST_WAIT, ST_STBY: begin
          if (int_en_reg & int_req_i) begin
            // Resume after the wait/stby instruction once the handler returns.
            pc_reg      <= pc_inc;
            state_reg   <= ST_INT;
            int_ack_reg <= 1'b1;
          end else if (state_reg == ST_STBY) begin
            clk_en_reg <= 1'b0;
          end
        end

        default: begin
          state_reg    <= ST_FETCH;
          inst_stb_reg <= 1'b1;
        end
      endcase
    end
  end

  assign inst_cyc_o = inst_stb_reg;
  assign inst_stb_o = inst_stb_reg;
  assign inst_adr_o = pc_reg;
  assign data_cyc_o = data_stb_reg;
  assign data_stb_o = data_stb_reg;
  assign data_we_o  = data_stb_reg & we_reg;
  assign port_cyc_o = port_stb_reg;
  assign port_stb_o = port_stb_reg;
  assign port_we_o  = port_stb_reg & we_reg;
  assign bus_adr_o  = bus_adr_reg;
  assign int_ack_o  = int_ack_reg;
  assign ClkEn_o    = clk_en_reg;
  assign RegWrt_c_o = reg_wrt_reg | (mem_load_reg & bus_ack);
  assign op2_c_o    = op2_reg;
  assign stm_mux_o  = stm_mux_reg;
  assign ALUFR_c_o  = alufr_reg;
  assign ALUEn_c_o  = aluen_reg;
  assign reti_c_o   = reti_reg;
  assign RegMux_c_o = reg_mux_reg;
  assign ALUOp_c_o  = aluop_reg;
  assign pc_o       = pc_reg;

endmodule

// File: tb/tb_gumnut_ctrl.sv
// tb_gumnut_ctrl
// Directed bench for gumnut_ctrl. The bench plays the part of punit and
// the memories: it supplies IR fields at fetch ack, acks bus cycles after
// a chosen number of wait cycles and checks controls and PC against
// hand-computed values.
module tb_gumnut_ctrl;

  localparam logic [6:0] OP_ALUI   = 7'b0000000;
  localparam logic [6:0] OP_MEM    = 7'b1000000;
  localparam logic [6:0] OP_ALUR   = 7'b1100000;
  localparam logic [6:0] OP_SHIFT  = 7'b1110000;
  localparam logic [6:0] OP_JUMP   = 7'b1111000;
  localparam logic [6:0] OP_BRANCH = 7'b1111100;
  localparam logic [6:0] OP_MISC   = 7'b1111110;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        inst_cyc_o, inst_stb_o;
  logic [11:0] inst_adr_o;
  logic        inst_ack_i = 1'b0;
  logic        data_cyc_o, data_stb_o, data_we_o;
  logic        port_cyc_o, port_stb_o, port_we_o;
  logic        data_ack_i = 1'b0;
  logic        port_ack_i = 1'b0;
  logic [7:0]  bus_adr_o;
  logic [6:0]  op_i = '0;
  logic [2:0]  func_i = '0;
  logic [11:0] addr_i = '0;
  logic [7:0]  disp_i = '0;
  logic [7:0]  res_i = '0;
  logic        ccC_i = 1'b0;
  logic        ccZ_i = 1'b0;
  logic        int_req_i = 1'b0;
  logic        int_ack_o;
  logic        ClkEn_o, RegWrt_c_o, op2_c_o, stm_mux_o, ALUFR_c_o, ALUEn_c_o, reti_c_o;
  logic [1:0]  RegMux_c_o;
  logic [3:0]  ALUOp_c_o;
  logic [11:0] pc_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  gumnut_ctrl #(
    .RS_DEPTH   (8),
    .INT_VECTOR (12'h001)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inst_cyc_o (inst_cyc_o),
    .inst_stb_o (inst_stb_o),
    .inst_adr_o (inst_adr_o),
    .inst_ack_i (inst_ack_i),
    .data_cyc_o (data_cyc_o),
    .data_stb_o (data_stb_o),
    .data_we_o  (data_we_o),
    .port_cyc_o (port_cyc_o),
    .port_stb_o (port_stb_o),
    .port_we_o  (port_we_o),
    .data_ack_i (data_ack_i),
    .port_ack_i (port_ack_i),
    .bus_adr_o  (bus_adr_o),
    .op_i       (op_i),
    .func_i     (func_i),
    .addr_i     (addr_i),
    .disp_i     (disp_i),
    .res_i      (res_i),
    .ccC_i      (ccC_i),
    .ccZ_i      (ccZ_i),
    .int_req_i  (int_req_i),
    .int_ack_o  (int_ack_o),
    .ClkEn_o    (ClkEn_o),
    .RegWrt_c_o (RegWrt_c_o),
    .op2_c_o    (op2_c_o),
    .stm_mux_o  (stm_mux_o),
    .ALUFR_c_o  (ALUFR_c_o),
    .ALUEn_c_o  (ALUEn_c_o),
    .reti_c_o   (reti_c_o),
    .RegMux_c_o (RegMux_c_o),
    .ALUOp_c_o  (ALUOp_c_o),
    .pc_o       (pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the fetch request, present the IR fields and ack.
  // Returns with the DUT in DECODE.
  task automatic do_fetch(input logic [6:0] op, input logic [2:0] fn,
                          input logic [11:0] adr, input logic [7:0] dsp);
    for (int n = 0; n < 20 && !inst_stb_o; n++) tick();
    check("fetch_stb", inst_stb_o, 1);
    check("fetch_adr", inst_adr_o, pc_o);
    op_i       = op;
    func_i     = fn;
    addr_i     = adr;
    disp_i     = dsp;
    inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
  endtask

  task automatic run_alu(input logic [6:0] op, input logic [2:0] fn, input logic exp_op2,
                         input logic [3:0] exp_aluop, input logic [11:0] exp_pc);
    do_fetch(op, fn, 12'h000, 8'h00);
    tick();
    check("alu_regwrt", RegWrt_c_o, 1);
    check("alu_alufr", ALUFR_c_o, 1);
    check("alu_aluen", ALUEn_c_o, 1);
    check("alu_op2", op2_c_o, exp_op2);
    check("alu_aluop", ALUOp_c_o, exp_aluop);
    check("alu_regmux", RegMux_c_o, 0);
    tick();
    check("alu_pc", pc_o, exp_pc);
    $display("txn alu op=%b func=%0d pc=%03h", op, fn, pc_o);
  endtask

  task automatic run_flow(input string tag, input logic [6:0] op, input logic [2:0] fn,
                          input logic [11:0] adr, input logic [7:0] dsp,
                          input logic exp_reti, input logic [11:0] exp_pc);
    do_fetch(op, fn, adr, dsp);
    tick();
    check({tag, "_regwrt"}, RegWrt_c_o, 0);
    check({tag, "_reti"}, reti_c_o, exp_reti);
    tick();
    check({tag, "_pc"}, pc_o, exp_pc);
    $display("txn %s op=%b func=%0d pc=%03h", tag, op, fn, pc_o);
  endtask

  task automatic run_mem(input logic [2:0] fn, input logic [7:0] res, input int waits,
                         input logic is_port, input logic exp_wrt, input logic [1:0] exp_mux,
                         input logic [11:0] exp_pc);
    string t;
    t = $sformatf("mem%0d", fn);
    do_fetch(OP_MEM, fn, 12'h000, 8'h00);
    tick();
    check({t, "_op2"}, op2_c_o, 1);
    check({t, "_aluop"}, ALUOp_c_o, 0);
    res_i = res;
    tick();
    check({t, "_adr"}, bus_adr_o, res);
    for (int i = 0; i < waits; i++) begin
      check({t, "_stb_wait"}, is_port ? port_stb_o : data_stb_o, 1);
      check({t, "_wrt_wait"}, RegWrt_c_o, 0);
      tick();
    end
    check({t, "_stb"}, is_port ? port_stb_o : data_stb_o, 1);
    check({t, "_cyc"}, is_port ? port_cyc_o : data_cyc_o, 1);
    check({t, "_other_stb"}, is_port ? data_stb_o : port_stb_o, 0);
    check({t, "_we"}, is_port ? port_we_o : data_we_o, fn[0]);
    check({t, "_stm_mux"}, stm_mux_o, fn[0]);
    if (is_port) port_ack_i = 1'b1;
    else         data_ack_i = 1'b1;
    #1;
    check({t, "_wrt_ack"}, RegWrt_c_o, exp_wrt);
    check({t, "_regmux"}, RegMux_c_o, exp_mux);
    tick();
    data_ack_i = 1'b0;
    port_ack_i = 1'b0;
    check({t, "_stb_done"}, is_port ? port_stb_o : data_stb_o, 0);
    check({t, "_pc"}, pc_o, exp_pc);
    $display("txn mem func=%0d adr=%02h waits=%0d pc=%03h", fn, res, waits, pc_o);
  endtask

  initial begin
    logic [11:0] exp_ret;

    // Reset state
    tick();
    tick();
    check("rst_inst_stb", inst_stb_o, 0);
    check("rst_inst_cyc", inst_cyc_o, 0);
    check("rst_data_stb", data_stb_o, 0);
    check("rst_port_stb", port_stb_o, 0);
    check("rst_pc", pc_o, 12'h000);
    check("rst_clken", ClkEn_o, 1);
    check("rst_regwrt", RegWrt_c_o, 0);
    check("rst_alufr", ALUFR_c_o, 0);
    check("rst_reti", reti_c_o, 0);
    check("rst_int_ack", int_ack_o, 0);
    rst_i = 1'b0;
    cyc   = 0;
    $display("txn reset released");

    // addi at PC 0: EXECUTE lands in cycle 3
    do_fetch(OP_ALUI, 3'd0, 12'h000, 8'h00);
    tick();
    check("addi_cycle", cyc, 3);
    check("addi_regwrt", RegWrt_c_o, 1);
    check("addi_alufr", ALUFR_c_o, 1);
    check("addi_op2", op2_c_o, 1);
    check("addi_aluop", ALUOp_c_o, 0);
    tick();
    check("addi_pc", pc_o, 12'h001);
    check("addi_regwrt_off", RegWrt_c_o, 0);
    $display("txn addi pc=%03h", pc_o);

    run_alu(OP_ALUR, 3'd5, 1'b0, 4'd5, 12'h002);
    run_alu(OP_SHIFT, 3'd3, 1'b0, 4'd11, 12'h003);

    // Memory: ldm with 3 wait cycles, stm, inp, out
    run_mem(3'd0, 8'h40, 3, 1'b0, 1'b1, 2'd1, 12'h004);
    run_mem(3'd1, 8'h12, 1, 1'b0, 1'b0, 2'd0, 12'h005);

    // bz -2 from PC 5, taken then not taken
    ccZ_i = 1'b1;
    run_flow("bz_taken", OP_BRANCH, 3'd0, 12'h000, 8'hFE, 1'b0, 12'h004);
    run_mem(3'd2, 8'h80, 0, 1'b1, 1'b1, 2'd2, 12'h005);
    ccZ_i = 1'b0;
    run_flow("bz_not", OP_BRANCH, 3'd0, 12'h000, 8'hFE, 1'b0, 12'h006);
    run_mem(3'd3, 8'h81, 2, 1'b1, 1'b0, 2'd0, 12'h007);
    ccC_i = 1'b1;
    run_flow("bc_taken", OP_BRANCH, 3'd2, 12'h000, 8'h10, 1'b0, 12'h018);
    ccC_i = 1'b0;

    // jmp, jsb, ret
    run_flow("jmp", OP_JUMP, 3'd0, 12'h020, 8'h00, 1'b0, 12'h020);
    run_flow("jsb", OP_JUMP, 3'd1, 12'h100, 8'h00, 1'b0, 12'h100);
    run_flow("ret", OP_MISC, 3'd0, 12'h000, 8'h00, 1'b0, 12'h021);

    // Nine nested calls into an 8-deep stack: pushes are 0x022, then
    // 0x201, 0x211, ... 0x271. The oldest (0x022) is overwritten by 0x271.
    for (int k = 0; k < 9; k++) begin
      run_flow("jsb_nest", OP_JUMP, 3'd1, 12'h200 + 12'(k * 16), 8'h00, 1'b0,
               12'h200 + 12'(k * 16));
    end
    for (int j = 0; j < 9; j++) begin
      if (j < 8) exp_ret = 12'h201 + 12'((7 - j) * 16);
      else       exp_ret = 12'h271;
      run_flow("ret_nest", OP_MISC, 3'd0, 12'h000, 8'h00, 1'b0, exp_ret);
    end

    // enai, then an interrupt requested during ldm: ldm finishes first
    run_flow("enai", OP_MISC, 3'd2, 12'h000, 8'h00, 1'b0, 12'h272);
    int_req_i = 1'b1;
    run_mem(3'd0, 8'h55, 0, 1'b0, 1'b1, 2'd1, 12'h273);
    check("int_ack_pulse", int_ack_o, 1);
    check("int_no_fetch", inst_stb_o, 0);
    tick();
    check("int_vector_pc", pc_o, 12'h001);
    check("int_ack_clear", int_ack_o, 0);
    check("int_en_cleared", inst_stb_o, 1);
    $display("txn interrupt entry pc=%03h", pc_o);
    int_req_i = 1'b0;

    // reti back to the interrupted flow
    run_flow("reti", OP_MISC, 3'd1, 12'h000, 8'h00, 1'b1, 12'h273);

    // stby: clocks gated until an interrupt (enabled by reti)
    do_fetch(OP_MISC, 3'd5, 12'h000, 8'h00);
    tick();
    tick();
    check("stby_clken", ClkEn_o, 0);
    tick();
    tick();
    check("stby_clken_hold", ClkEn_o, 0);
    check("stby_pc", pc_o, 12'h273);
    int_req_i = 1'b1;
    tick();
    check("stby_int_ack", int_ack_o, 1);
    check("stby_clken_on", ClkEn_o, 1);
    int_req_i = 1'b0;
    tick();
    check("stby_int_pc", pc_o, 12'h001);
    $display("txn stby wake pc=%03h", pc_o);

    // Reset while a fetch is outstanding
    check("pre_rst_stb", inst_stb_o, 1);
    rst_i = 1'b1;
    tick();
    check("mid_rst_stb", inst_stb_o, 0);
    check("mid_rst_pc", pc_o, 12'h000);
    check("mid_rst_clken", ClkEn_o, 1);
    rst_i = 1'b0;
    $display("txn reset mid-fetch");

    // Request with interrupts disabled is ignored
    int_req_i = 1'b1;
    tick();
    check("int_ignored_stb", inst_stb_o, 1);
    check("int_ignored_ack", int_ack_o, 0);
    int_req_i = 1'b0;
    $display("txn masked request");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
